da_serial_fir3: RTL and testbench



---
 rtl/da_fir_pkg.sv | 13 +
 rtl/da_tap_sreg.sv | 21 ++
 rtl/da_serial_fir3.sv | 99 +++++++++
 tb/tb_da_serial_fir3.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/da_fir_pkg.sv
// Shared constants for the bit-serial DA 3-tap FIR: default widths,
// filter coefficients and state encoding.
package da_fir_pkg;
  localparam int B_DEF = 8;
  localparam int W_DEF = 12;

  localparam int C0 = -2;
  localparam int C1 = 3;
  localparam int C2 = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
endpackage

// File: rtl/da_tap_sreg.sv
// B-bit parallel-load, MSB-out left-shift register; load wins over shift.
module da_tap_sreg #(
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [B-1:0] d,
  output logic         msb
);
  logic [B-1:0] q;

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {q[B-2:0], 1'b0};
  end

  assign msb = q[B-1];
endmodule

// File: rtl/da_serial_fir3.sv
// Bit-serial DA engine for a 3-tap FIR (-2, 3, 1) with an external DA table.
// Define DA_FIR_SAT_EN to clamp y to the B-bit signed range.
module da_serial_fir3
  import da_fir_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = B + 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] x_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [2:0]   table_in,
  input  logic [3:0]   table_out,
  output logic [W-1:0] y,
  output logic         y_valid,
  output logic         busy
);
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  logic [0:0]          state;
  logic [B-1:0]        x0, x1, x2;
  logic [CW-1:0]       count;
  logic signed [W-1:0] acc, t, acc_nx, y_fin;
  logic                accept, last;
  logic [2:0]          msb;
  logic [2:0][B-1:0]   ld_d;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);
  assign accept   = in_valid && in_ready;
  assign last     = busy && (count == CW'(B - 1));

  // Shift regs load the post-shift delay line: s0<-x_in, s1<-x0, s2<-x1.
  assign ld_d = {x1, x0, x_in};

  for (genvar i = 0; i < 3; i++) begin : g_tap
    da_tap_sreg #(.B(B)) u_tap (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .shift (busy),
      .d     (ld_d[i]),
      .msb   (msb[i])
    );
  end

  assign table_in = busy ? msb : 3'b000;
  assign t        = {{(W-4){table_out[3]}}, table_out};

  // The MSB slice carries the negative two's-complement weight.
  assign acc_nx = (count == '0) ? -t : (acc <<< 1) + t;

`ifdef DA_FIR_SAT_EN
  localparam logic signed [W-1:0] SMAX = W'((1 << (B - 1)) - 1);
  localparam logic signed [W-1:0] SMIN = ~SMAX;

  always_comb begin
    y_fin = acc_nx;
    if (acc_nx > SMAX)      y_fin = SMAX;
    else if (acc_nx < SMIN) y_fin = SMIN;
  end
`else
  assign y_fin = acc_nx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      count   <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          x2    <= x1;
          x1    <= x0;
          x0    <= x_in;
          count <= '0;
          state <= RUN;
        end
      end else begin
        acc   <= acc_nx;
        count <= count + CW'(1);
        if (last) begin
          y       <= y_fin;
          y_valid <= 1'b1;
          state   <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_da_serial_fir3.sv
// Self-checking bench for da_serial_fir3: external DA table, behavioural
// FIR model with per-cycle comparison, plus directed literal checks.
module tb_da_serial_fir3;
  import da_fir_pkg::*;

  localparam int B = B_DEF;
  localparam int W = W_DEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [B-1:0] x_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   table_in;
  logic [3:0]   table_out;
  logic [W-1:0] y;
  logic         y_valid;
  logic         busy;

  da_serial_fir3 #(.B(B), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .table_in  (table_in),
    .table_out (table_out),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tbl(input logic [2:0] a);
    int v;
    v = C0 * int'(a[0]) + C1 * int'(a[1]) + C2 * int'(a[2]);
    return v[3:0];
  endfunction

  assign table_out = tbl(table_in);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
`ifdef DA_FIR_SAT_EN
    int hi, lo;
    hi = (1 << (B - 1)) - 1;
    lo = -(1 << (B - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
`endif
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int           due;
    int           yv;
    logic [B-1:0] s0, s1, s2;
  } pend_t;

  pend_t               pq[$];
  int                  edge_n = 0;
  bit                  started = 0;
  logic signed [B-1:0] h0 = '0, h1 = '0, h2 = '0;
  int                  exp_y = 0;
  int                  got[$];

  always @(posedge clk) begin
    pend_t p;
    edge_n++;
    if (reset) begin
      started = 1;
      pq.delete();
      h0 = '0; h1 = '0; h2 = '0;
      exp_y = 0;
    end else if (started && in_valid && in_ready) begin
      h2 = h1; h1 = h0; h0 = x_in;
      p.due = edge_n + B;
      p.yv  = sat(C0 * int'(h0) + C1 * int'(h1) + C2 * int'(h2));
      p.s0 = h0; p.s1 = h1; p.s2 = h2;
      pq.push_back(p);
    end
  end

  always @(negedge clk) begin
    bit         ev, run;
    logic [2:0] etab;
    int         pos;
    if (started) begin
      ev = 0; run = 0; etab = 3'b000;
      if (pq.size() > 0) begin
        if (pq[0].due == edge_n) begin
          ev = 1;
          exp_y = pq[0].yv;
        end else if (pq[0].due > edge_n) begin
          run = 1;
          pos = B - 1 - (edge_n - (pq[0].due - B));
          etab = {pq[0].s2[pos], pq[0].s1[pos], pq[0].s0[pos]};
        end
      end
      chk("y_valid", int'(y_valid), int'(ev));
      chk("y", int'($signed(y)), exp_y);
      chk("in_ready", int'(in_ready), int'(!run));
      chk("busy", int'(busy), int'(run));
      chk("table_in", int'(table_in), int'(etab));
      if (ev) pq.pop_front();
      if (y_valid) got.push_back(int'($signed(y)));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [B-1:0] v, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Called right after send(): accept negedge counts as cycle 0.
  task automatic wait_y(input string name, input bit cv, input int expv);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!y_valid && n < 50);
    chk({name, "_latency"}, n, B + 1);
    if (cv) chk(name, int'($signed(y)), expv);
  endtask

  int tr_exp[8] = '{1, 2, 0, 0, 0, 0, 0, 1};

  initial begin
    // reset state
    do_reset();
    chk("rst_y", int'(y), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);

    // impulse
    send(8'd1, 0); wait_y("imp0", 1, -2);
    send(8'd0, 0); wait_y("imp1", 1, 3);
    send(8'd0, 0); wait_y("imp2", 1, 1);

    // extremes
    do_reset();
    send(8'd127, 0); wait_y("ext0", 0, 0);
    send(8'd127, 0); wait_y("ext1", 0, 0);
    send(8'h80, 0);
`ifdef DA_FIR_SAT_EN
    wait_y("ext2", 1, 127);
`else
    wait_y("ext2", 1, 764);
`endif
    do_reset();
    send(8'h80, 0); wait_y("neg0", 0, 0);
    send(8'h80, 0); wait_y("neg1", 0, 0);
    send(8'h80, 0);
`ifdef DA_FIR_SAT_EN
    wait_y("neg2", 1, -128);
`else
    wait_y("neg2", 1, -256);
`endif

    // backpressure: in_valid held high across all three samples
    do_reset();
    got.delete();
    send(8'd1, 1);
    send(8'd2, 1);
    send(8'd3, 0);
    repeat (12) @(negedge clk);
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_y0", got[0], -2);
      chk("bp_y1", got[1], -1);
      chk("bp_y2", got[2], 1);
    end

    // reset mid-run at count 4
    got.delete();
    send(8'd5, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_y", int'(y), 0);
    chk("mid_in_ready", int'(in_ready), 1);
    chk("mid_y_valid", int'(y_valid), 0);
    repeat (10) @(negedge clk);
    chk("mid_no_result", got.size(), 0);
    send(8'd1, 0); wait_y("mid_after", 1, -2);

    // table_in trace
    do_reset();
    send(8'h40, 0); wait_y("tr_pre", 0, 0);
    send(8'h81, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("trace%0d", k), int'(table_in), tr_exp[k]);
    end
    repeat (3) @(negedge clk);

    // randomized traffic: x_in changes every cycle, including during RUN
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 7);
      x_in = B'($urandom);
      reset = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2 * B + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
